// File: rtl/mem_router_pkg.sv
// Shared types and decode helpers for the memory-bus router.
package mem_router_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int unsigned MAX_BANKS = 4;

  // Read latency nibble of bank `sel` from the packed latency table.
  function automatic logic [3:0] bank_lat(input logic [15:0] lat, input int unsigned sel);
    logic [15:0] sh;
    sh = lat >> (sel * 4);
    return (sel < MAX_BANKS) ? sh[3:0] : 4'd0;
  endfunction

  function automatic logic bank_mapped(input int unsigned sel, input int unsigned num_banks);
    return sel < num_banks;
  endfunction

endpackage

// File: rtl/mem_router.sv
// Memory-bus router: decodes the bank-select field, strobes one bank per
// accepted request and returns a single-cycle response after the bank latency.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned SEL_LO    = 17,
  parameter int unsigned SEL_W     = 2,
  parameter logic [15:0] BANK_LAT  = 16'h1111
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [3:0]                req_wmask,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [31:0]               err_addr,
  output logic [NUM_BANKS-1:0]      bank_en,
  output logic [NUM_BANKS-1:0]      bank_write,
  output logic [4*NUM_BANKS-1:0]    bank_wmask,
  output logic [31:0]               bank_addr,
  output logic [31:0]               bank_wdata,
  input  logic [32*NUM_BANKS-1:0]   bank_rdata
);

  if (NUM_BANKS < 1 || NUM_BANKS > MAX_BANKS || (1 << SEL_W) < NUM_BANKS) begin : g_bad_cfg
    $error("mem_router: illegal NUM_BANKS/SEL_W combination");
  end

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [SEL_W-1:0] sel, sel_q;
  logic             write_q, err_q;
  logic             mapped, accept;
  logic [3:0]       lat_sel, cnt_load;
  logic [31:0]      rd_mux;

  assign sel      = req_addr[SEL_LO +: SEL_W];
  assign mapped   = bank_mapped(32'(sel), NUM_BANKS);
  assign lat_sel  = bank_lat(BANK_LAT, 32'(sel));
  assign cnt_load = (mapped && !req_write) ? lat_sel : 4'd1;

  assign resp_valid = (state == WAIT) && (cnt == 4'd1);
  assign req_ready  = (state == IDLE) || resp_valid;
  // A request presented while reset is held must not reach any bank.
  assign accept     = req_valid && req_ready && !rst;

  assign bank_addr  = req_addr;
  assign bank_wdata = req_wdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = cnt_load;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          if (accept) begin
            state_nxt = WAIT;
            cnt_nxt   = cnt_load;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        sel_q   <= sel;
        write_q <= req_write;
        err_q   <= !mapped;
        if (!mapped) err_addr <= req_addr;
      end
    end
  end

  always_comb begin
    bank_en    = '0;
    bank_write = '0;
    bank_wmask = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (accept && mapped && (sel == SEL_W'(i))) begin
        bank_en[i] = 1'b1;
        if (req_write) begin
          bank_write[i]       = 1'b1;
          bank_wmask[4*i +: 4] = req_wmask;
        end
      end
    end
  end

  // Read data follows the registered select, so a response overlapping a new
  // accept still returns the previous bank's data.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (sel_q == SEL_W'(i)) rd_mux = bank_rdata[32*i +: 32];
    end
  end

  assign resp_rdata = (resp_valid && !err_q && !write_q) ? rd_mux : '0;
  assign resp_err   = resp_valid && err_q;

  always_ff @(posedge clk) begin
    if (accept && mapped && !req_write) assert (lat_sel != 4'd0);
  end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_router;

  localparam int unsigned NB = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [3:0]    req_wmask;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [31:0]   err_addr;
  logic [NB-1:0] bank_en;
  logic [NB-1:0] bank_write;
  logic [4*NB-1:0]  bank_wmask;
  logic [31:0]   bank_addr;
  logic [31:0]   bank_wdata;
  logic [32*NB-1:0] bank_rdata;

  logic [31:0] bdata [NB];
  int unsigned lat_tab [NB] = '{1, 2, 1, 3};

  int checks = 0;
  int failures = 0;

  assign bank_rdata = {bdata[3], bdata[2], bdata[1], bdata[0]};

  mem_router #(
    .NUM_BANKS(NB),
    .SEL_LO(17),
    .SEL_W(3),
    .BANK_LAT(16'h3121)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .err_addr(err_addr), .bank_en(bank_en), .bank_write(bank_write),
    .bank_wmask(bank_wmask), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wmask = m; req_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h want=0", resp_rdata); end
    checks++; if (err_addr !== 32'h0) begin failures++; $display("FAIL rst_err_addr got=%h want=0", err_addr); end
    checks++; if ({bank_en, bank_write, bank_wmask} !== '0) begin failures++; $display("FAIL rst_banks got=%h/%h/%h want=0", bank_en, bank_write, bank_wmask); end
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_req_ignored got=%b want=0", resp_valid); end
      next_cycle();
    end
  endtask

  task automatic test_read_l1();
    bdata[0] = 32'hDEAD_BEEF;
    drive(1'b1, 1'b0, 32'h0000_0010, 4'h0, '0);
    @(negedge clk);
    checks++; if (bank_en !== 4'b0001) begin failures++; $display("FAIL l1_en got=%b want=0001", bank_en); end
    checks++; if (bank_write !== 4'b0000) begin failures++; $display("FAIL l1_write got=%b want=0000", bank_write); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL l1_valid got=%b want=1", resp_valid); end
    checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL l1_rdata got=%h want=deadbeef", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL l1_err got=%b want=0", resp_err); end
    next_cycle();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL l1_single_strobe got=%b want=0", resp_valid); end
    next_cycle();
  endtask

  task automatic test_read_l2();
    bdata[1] = 32'hCAFE_0001;
    drive(1'b1, 1'b0, 32'h0002_0004, 4'h0, '0);
    @(negedge clk);
    checks++; if (bank_en !== 4'b0010) begin failures++; $display("FAIL l2_en got=%b want=0010", bank_en); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL l2_ready_c1 got=%b want=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL l2_valid_c1 got=%b want=0", resp_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL l2_valid_c2 got=%b want=1", resp_valid); end
    checks++; if (resp_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL l2_rdata got=%h want=cafe0001", resp_rdata); end
    next_cycle();
  endtask

  task automatic test_write();
    bdata[0] = 32'h5555_AAAA;
    drive(1'b1, 1'b1, 32'h0000_0008, 4'b0011, 32'h0BAD_F00D);
    @(negedge clk);
    checks++; if (bank_wmask !== 16'h0003) begin failures++; $display("FAIL wr_wmask got=%h want=0003", bank_wmask); end
    checks++; if (bank_write !== 4'b0001) begin failures++; $display("FAIL wr_write got=%b want=0001", bank_write); end
    checks++; if (bank_wdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL wr_wdata got=%h want=0badf00d", bank_wdata); end
    checks++; if (bank_addr !== 32'h0000_0008) begin failures++; $display("FAIL wr_addr got=%h want=00000008", bank_addr); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL wr_valid got=%b want=1", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rdata got=%h want=0", resp_rdata); end
    next_cycle();
  endtask

  task automatic test_unmapped();
    drive(1'b1, 1'b0, 32'h0008_0000, 4'h0, '0);
    @(negedge clk);
    checks++; if ({bank_en, bank_wmask} !== '0) begin failures++; $display("FAIL um_banks got=%b/%h want=0", bank_en, bank_wmask); end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL um_valid got=%b want=1", resp_valid); end
    checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL um_err got=%b want=1", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL um_rdata got=%h want=0", resp_rdata); end
    checks++; if (err_addr !== 32'h0008_0000) begin failures++; $display("FAIL um_err_addr got=%h want=00080000", err_addr); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int unsigned sels [10];
    int unsigned s;
    for (int k = 0; k <= 11; k++) begin
      for (int b = 0; b < 4; b++) bdata[b] = $urandom;
      if (k < 10) begin
        s = ($urandom_range(0, 1) == 0) ? 0 : 2;
        sels[k] = s;
        drive(1'b1, 1'b0, (32'(s) << 17) | ($urandom & 32'h0001_FFFC), 4'h0, '0);
      end else begin
        drive(1'b0, 1'b0, '0, '0, '0);
      end
      @(negedge clk);
      if (k <= 10) begin
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%b want=1", k, req_ready); end
      end
      if (k >= 1 && k <= 10) begin
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid k=%0d got=%b want=1", k, resp_valid); end
        checks++; if (resp_rdata !== bdata[sels[k-1]]) begin failures++; $display("FAIL b2b_rdata k=%0d got=%h want=%h", k, resp_rdata, bdata[sels[k-1]]); end
      end else begin
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle k=%0d got=%b want=0", k, resp_valid); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'h0009_0000, 4'h0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0006_0000, 4'h0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rm_valid_in_rst got=%b want=0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready_in_rst got=%b want=1", req_ready); end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rm_no_resp k=%0d got=%b want=0", k, resp_valid); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready k=%0d got=%b want=1", k, req_ready); end
      checks++; if (err_addr !== 32'h0) begin failures++; $display("FAIL rm_err_addr k=%0d got=%h want=0", k, err_addr); end
      next_cycle();
    end
  endtask

  // Reference model: one outstanding transaction, response due at accept
  // cycle + latency (latency 1 for writes and unmapped accesses).
  task automatic test_random(input int n);
    bit          busy = 0;
    bit          hold = 0;
    int          resp_at = 0;
    int unsigned p_sel = 0;
    bit          p_write = 0, p_err = 0;
    logic [31:0] err_m = 32'h0;
    logic [31:0] exp_rd;
    logic [NB-1:0] exp_en, exp_wr;
    logic [4*NB-1:0] exp_m;
    int unsigned s;
    bit exp_ready, exp_valid, mapped, acc;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int b = 0; b < 4; b++) bdata[b] = $urandom;
      if (!hold) begin
        if ($urandom_range(0, 9) < 7) begin
          s = $urandom_range(0, 5);
          drive(1'b1, 1'($urandom), ($urandom & ~(32'h7 << 17)) | (32'(s) << 17),
                4'($urandom), $urandom);
        end else begin
          drive(1'b0, 1'b0, $urandom, 4'($urandom), $urandom);
        end
      end
      @(negedge clk);
      exp_ready = !busy || (cyc == resp_at);
      exp_valid = busy && (cyc == resp_at);
      s = 32'(req_addr[19:17]);
      mapped = (s < NB);
      acc = req_valid && exp_ready;
      exp_en = '0; exp_wr = '0; exp_m = '0;
      if (acc && mapped) begin
        exp_en[s] = 1'b1;
        if (req_write) begin
          exp_wr[s] = 1'b1;
          exp_m[4*s +: 4] = req_wmask;
        end
      end
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready); end
      checks++; if (resp_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, resp_valid, exp_valid); end
      if (exp_valid) begin
        exp_rd = (p_err || p_write) ? 32'h0 : bdata[p_sel];
        checks++; if (resp_rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, resp_rdata, exp_rd); end
        checks++; if (resp_err !== p_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", cyc, resp_err, p_err); end
      end
      checks++; if (bank_en !== exp_en) begin failures++; $display("FAIL rnd_en cyc=%0d got=%b want=%b", cyc, bank_en, exp_en); end
      checks++; if (bank_write !== exp_wr) begin failures++; $display("FAIL rnd_write cyc=%0d got=%b want=%b", cyc, bank_write, exp_wr); end
      checks++; if (bank_wmask !== exp_m) begin failures++; $display("FAIL rnd_wmask cyc=%0d got=%h want=%h", cyc, bank_wmask, exp_m); end
      checks++; if (err_addr !== err_m) begin failures++; $display("FAIL rnd_err_addr cyc=%0d got=%h want=%h", cyc, err_addr, err_m); end
      if (exp_valid) busy = 0;
      if (acc) begin
        busy    = 1;
        resp_at = cyc + int'((mapped && !req_write) ? lat_tab[s] : 1);
        p_sel   = s;
        p_write = req_write;
        p_err   = !mapped;
        if (!mapped) err_m = req_addr;
      end
      hold = req_valid && !acc;
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (4) next_cycle();
  endtask

  initial begin
    for (int b = 0; b < 4; b++) bdata[b] = 32'h0;
    test_reset();
    test_read_l1();
    test_read_l2();
    test_write();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
